// File: rtl/lsu_dmem_master_if.sv
// Core-side request/response channel and data-memory port of the LSU master.
// The master modport is the LSU; the slave modport is the core plus memory side.
interface lsu_dmem_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_we;
    logic [31:0] mem_rdata;

    modport master (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_wdata, mem_we
    );

    modport slave (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/lsu_dmem_master.sv
// Load/store unit master: checks alignment and range of one core request at a time,
// drives a single-cycle store or a registered-read load, and returns an extended response.
module lsu_dmem_master #(
    parameter int unsigned MEM_BYTES = 4096
) (
    input  logic               clk,
    input  logic               rst_n,
    lsu_dmem_master_if.master  bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_e;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [3:0]  mem_we_c;
    logic [3:0]  we_mask;
    logic [31:0] load_ext;
    logic [2:0]  nbytes;
    logic [32:0] last_byte;
    logic        req_err;

    // Last touched byte is computed 33 bits wide so addresses near 2^32 cannot wrap into range.
    always_comb begin
        case (bus.req_size)
            2'b00:   nbytes = 3'd1;
            2'b01:   nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
        last_byte = {1'b0, bus.req_addr} + 33'(nbytes) - 33'd1;
        req_err   = (bus.req_size == 2'b11)
                  | ((bus.req_size == 2'b01) & bus.req_addr[0])
                  | ((bus.req_size == 2'b10) & (bus.req_addr[1:0] != 2'b00))
                  | (last_byte >= 33'(MEM_BYTES));
    end

    always_comb begin
        case (size_q)
            2'b00:   we_mask = 4'b0001;
            2'b01:   we_mask = 4'b0011;
            2'b10:   we_mask = 4'b1111;
            default: we_mask = 4'b0000;
        endcase
        case (size_q)
            2'b00:   load_ext = uns_q ? {24'b0, bus.mem_rdata[7:0]}
                                      : {{24{bus.mem_rdata[7]}}, bus.mem_rdata[7:0]};
            2'b01:   load_ext = uns_q ? {16'b0, bus.mem_rdata[15:0]}
                                      : {{16{bus.mem_rdata[15]}}, bus.mem_rdata[15:0]};
            default: load_ext = bus.mem_rdata;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        size_d   = size_q;
        uns_d    = uns_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        mem_we_c = '0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    size_d  = bus.req_size;
                    uns_d   = bus.req_unsigned;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    rdata_d = '0;
                    err_d   = req_err;
                    state_d = req_err ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    mem_we_c = we_mask;
                    state_d  = RESP;
                end else begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                rdata_d = load_ext;
                state_d = RESP;
            end
            RESP: begin
                if (bus.resp_ready) state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.mem_we     = mem_we_c;

endmodule

// File: doc/lsu_dmem_master.md
LSU_DMEM_MASTER -- requirements
Module: lsu_dmem_master

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 4096, meaning the size in bytes of the attached data memory.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-004 SHALL have port req_valid, input, 1, core request present.
REQ-005 SHALL have port req_ready, output, 1, block can accept a request.
REQ-006 SHALL have port req_we, input, 1, 1 = store, 0 = load.
REQ-007 SHALL have port req_size, input, 2, access size: 00 byte, 01 half, 10 word, 11 illegal.
REQ-008 SHALL have port req_unsigned, input, 1, load zero-extends when 1 and sign-extends when 0.
REQ-009 SHALL have port req_addr, input, 32, byte address.
REQ-010 SHALL have port req_wdata, input, 32, store data, right-justified.
REQ-011 SHALL have port resp_valid, output, 1, response present.
REQ-012 SHALL have port resp_ready, input, 1, core accepts the response.
REQ-013 SHALL have port resp_rdata, output, 32, extended load data; 0 for stores and errors.
REQ-014 SHALL have port resp_err, output, 1, the request was misaligned, out of range or had an illegal size.
REQ-015 SHALL have port mem_addr, output, 32, byte address to the data memory.
REQ-016 SHALL have port mem_wdata, output, 32, write data to the memory; byte lane k drives byte addr+k.
REQ-017 SHALL have port mem_we, output, 4, per-lane write enables.
REQ-018 SHALL have port mem_rdata, input, 32, registered memory read data; valid one clock after mem_addr is presented.

Function
REQ-019 SHALL implement states IDLE, ISSUE, CAPTURE and RESP; req_ready SHALL be 1 only in IDLE.
REQ-020 SHALL accept a request on a clk edge with req_valid=1 in IDLE, registering we, size, unsigned, addr and wdata.
REQ-021 SHALL flag an error at accept when any of these holds:
- size=11;
- half with addr[0]=1;
- word with addr[1:0]!=0;
- addr+bytes-1 >= MEM_BYTES.
REQ-022 SHALL, on an error request, go IDLE->RESP with resp_err=1 and resp_rdata=0, and never assert mem_we for that request.
REQ-023 SHALL, on a legal request, go IDLE->ISSUE; in ISSUE, mem_addr=addr_q and mem_wdata=wdata_q.
REQ-024 SHALL, for a store in ISSUE, drive mem_we = 0001 (byte), 0011 (half) or 1111 (word).
REQ-025 SHALL assert mem_we in ISSUE only, for exactly one cycle per store.
REQ-026 SHALL move a store ISSUE->RESP and a load ISSUE->CAPTURE; loads SHALL keep mem_we=0000.
REQ-027 SHALL hold mem_addr=addr_q in CAPTURE and in RESP.
REQ-028 SHALL, in CAPTURE, register resp_rdata from mem_rdata and then go to RESP:
- byte: mem_rdata[7:0], extended by bit 7 or by zeros;
- half: mem_rdata[15:0], extended by bit 15 or by zeros;
- word: the full 32 bits.
REQ-029 SHALL give latency from the accept edge to resp_valid=1 of 3 cycles for a load, 2 for a store and 1 for an error.
REQ-030 SHALL hold resp_valid, resp_rdata and resp_err stable in RESP until resp_ready=1 on a clk edge, then return to IDLE.
REQ-031 SHALL NOT accept a new request in the same cycle as the RESP handshake; back-to-back requests take at least one IDLE cycle.
REQ-032 SHALL ignore req_* inputs outside IDLE; the request registers SHALL NOT change there.
REQ-033 SHALL drive resp_valid=0 in IDLE, ISSUE and CAPTURE.

Reset
REQ-034 SHALL, while rst_n=0, force asynchronously: state=IDLE, mem_we=0000, resp_valid=0, resp_rdata=0, resp_err=0, request registers=0, mem_addr=0, mem_wdata=0.
REQ-035 SHALL abort any in-flight request when reset asserts, with no response and no mem_we pulse after reset.
REQ-036 SHALL have req_ready=1 on the first clk edge after rst_n deasserts.

Verification
REQ-037 Store word, then load word:
- store addr=0x10, wdata=0xDEADBEEF, size=10 -> one cycle of mem_we=1111 with mem_addr=0x10; resp_valid on the 2nd cycle, resp_err=0;
- load addr=0x10 -> resp_rdata=0xDEADBEEF on the 3rd cycle.
REQ-038 Byte store and byte loads:
- store byte 0x80 at 0x21 -> mem_we=0001;
- signed byte load at 0x21 -> resp_rdata=0xFFFFFF80;
- unsigned byte load at 0x21 -> 0x00000080.
REQ-039 Half load after a half store of 0x8001 at 0x22:
- signed -> 0xFFFF8001;
- unsigned -> 0x00008001.
REQ-040 Error requests, each giving resp_err=1 after 1 cycle, resp_rdata=0 and mem_we never asserted:
- half at 0x23;
- word at 0x0FFE;
- word at 0x1000;
- size=11.
REQ-041 Response backpressure: resp_ready=0 for 5 cycles -> resp_valid and resp_rdata stable, req_ready=0; req_valid toggling during that time is ignored.
REQ-042 Reset mid-operation: pulse rst_n low during ISSUE of a store -> mem_we=0000 immediately, no write occurs, and req_ready=1 after release.
